// File: rtl/y86_bus_arbiter.sv
// Two-requester (CPU/DMA) memory bus arbiter with round-robin grant, wait-state
// tolerance and a MAX_WAIT abort that returns 32'hFFFFFFFF with timeout_err.
module y86_bus_arbiter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] bus_A,
  output logic [31:0] bus_out,
  output logic        bus_WE,
  output logic        bus_RE,
  input  logic [31:0] bus_in,
  input  logic        bus_ready,
  output logic        owner,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_ptr;       // 1 = DMA wins the next tie
  logic        r_owner;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [15:0] r_wait;
  logic        r_timeout;
  logic [31:0] r_c_rdata;
  logic [31:0] r_d_rdata;

  logic        w_any_req;
  logic        w_grant_d;
  logic        w_abort;

  assign w_any_req = c_req | d_req;
  assign w_grant_d = (c_req && d_req) ? r_ptr : d_req;
  assign w_abort   = (r_state == S_BUSY) && !bus_ready && (r_wait == 16'(MAX_WAIT));

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_next      = r_state;
    bus_A       = '0;
    bus_out     = '0;
    bus_WE      = 1'b0;
    bus_RE      = 1'b0;
    c_ack       = 1'b0;
    d_ack       = 1'b0;
    timeout_err = 1'b0;
    case (r_state)
      S_IDLE: if (w_any_req) w_next = S_BUSY;
      S_BUSY: begin
        bus_A   = r_addr;
        bus_out = r_wdata;
        bus_WE  = r_we && !w_abort;
        bus_RE  = !r_we && !w_abort;
        if (bus_ready || w_abort) w_next = S_DONE;
      end
      S_DONE: begin
        c_ack       = !r_owner;
        d_ack       = r_owner;
        timeout_err = r_timeout;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= 1'b0;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wait    <= '0;
      r_timeout <= 1'b0;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any_req) begin
          r_owner   <= w_grant_d;
          r_ptr     <= !w_grant_d;
          r_we      <= w_grant_d ? d_we    : c_we;
          r_addr    <= w_grant_d ? d_addr  : c_addr;
          r_wdata   <= w_grant_d ? d_wdata : c_wdata;
          r_wait    <= '0;
          r_timeout <= 1'b0;
        end
        S_BUSY: begin
          if (bus_ready) begin
            if (!r_we) begin
              if (r_owner) r_d_rdata <= bus_in;
              else         r_c_rdata <= bus_in;
            end
          end else if (w_abort) begin
            if (r_owner) r_d_rdata <= 32'hFFFF_FFFF;
            else         r_c_rdata <= 32'hFFFF_FFFF;
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign owner   = r_owner;
  assign c_rdata = r_c_rdata;
  assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_y86_bus_arbiter.sv
// Directed bench for y86_bus_arbiter: a transaction-level reference model is
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_y86_bus_arbiter;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_ack, d_ack;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] bus_A, bus_out, bus_in;
  logic        bus_WE, bus_RE, bus_ready;
  logic        owner, timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  y86_bus_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_A(bus_A), .bus_out(bus_out), .bus_WE(bus_WE), .bus_RE(bus_RE),
    .bus_in(bus_in), .bus_ready(bus_ready),
    .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one transfer in flight at a time, ack cycle afterwards.
  bit          m_active, m_done, m_to, m_owner, m_pref, m_we;
  int          m_waits;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rd [2];

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_done = 0; m_to = 0; m_owner = 0; m_pref = 0; m_we = 0;
      m_waits = 0; m_addr = 0; m_wdata = 0; m_rd[0] = 0; m_rd[1] = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (bus_ready) begin
        if (!m_we) m_rd[m_owner] = bus_in;
        m_active = 0; m_done = 1;
      end else if (m_waits == MAX_WAIT) begin
        m_rd[m_owner] = 32'hFFFF_FFFF;
        m_to = 1; m_active = 0; m_done = 1;
      end else begin
        m_waits++;
      end
    end else if (c_req || d_req) begin
      m_owner  = (c_req && d_req) ? m_pref : d_req;
      m_pref   = !m_owner;
      m_we     = m_owner ? d_we : c_we;
      m_addr   = m_owner ? d_addr : c_addr;
      m_wdata  = m_owner ? d_wdata : c_wdata;
      m_active = 1; m_waits = 0; m_to = 0;
    end
  end

  logic [31:0] e_a, e_out;
  logic        e_we, e_re, e_cack, e_dack, e_to, e_strobe;

  always @(negedge clk) begin
    if (chk_en) begin
      e_a = 0; e_out = 0; e_we = 0; e_re = 0; e_cack = 0; e_dack = 0; e_to = 0;
      if (m_done) begin
        e_cack = !m_owner; e_dack = m_owner; e_to = m_to;
      end else if (m_active) begin
        e_strobe = !(m_waits == MAX_WAIT && !bus_ready);
        e_a = m_addr; e_out = m_wdata;
        e_we = m_we && e_strobe; e_re = !m_we && e_strobe;
      end
      check("m_bus_A", bus_A, e_a);
      check("m_bus_out", bus_out, e_out);
      check("m_bus_WE", bus_WE, e_we);
      check("m_bus_RE", bus_RE, e_re);
      check("m_c_ack", c_ack, e_cack);
      check("m_d_ack", d_ack, e_dack);
      check("m_timeout", timeout_err, e_to);
      check("m_owner", owner, m_owner);
      check("m_c_rdata", c_rdata, m_rd[0]);
      check("m_d_rdata", d_rdata, m_rd[1]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; bus_in = 0; bus_ready = 0;
    cyc();
    chk_en = 1'b1;
    cyc();
    check("rst_owner", owner, 0);
    check("rst_bus_A", bus_A, 0);
    check("rst_c_rdata", c_rdata, 0);
    rst = 0;

    // CPU read, zero wait states
    c_req = 1; c_we = 0; c_addr = 32'h100; bus_in = 32'hDEAD_BEEF; bus_ready = 1;
    cyc(); c_req = 0; #2;
    check("rd_RE", bus_RE, 1);
    check("rd_A", bus_A, 32'h100);
    cyc(); #2;
    check("rd_c_ack", c_ack, 1);
    check("rd_c_rdata", c_rdata, 32'hDEAD_BEEF);
    check("rd_d_ack", d_ack, 0);
    cyc();
    bus_ready = 0;

    // DMA write with three wait states
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h1234_5678;
    cyc(); d_req = 0;
    for (int i = 0; i < 4; i++) begin
      bus_ready = (i == 3);
      #2;
      check("wr_WE", bus_WE, 1);
      check("wr_A", bus_A, 32'h20);
      check("wr_out", bus_out, 32'h1234_5678);
      cyc();
    end
    #2;
    check("wr_d_ack", d_ack, 1);
    check("wr_timeout", timeout_err, 0);
    check("wr_c_ack", c_ack, 0);
    cyc();
    bus_ready = 0;

    // CPU read that never completes: abort after MAX_WAIT waits
    c_req = 1; c_we = 0; c_addr = 32'h44;
    cyc(); c_req = 0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      #2; check("to_RE_on", bus_RE, 1);
      cyc();
    end
    #2; check("to_RE_off", bus_RE, 0);
    cyc(); #2;
    check("to_c_ack", c_ack, 1);
    check("to_err", timeout_err, 1);
    check("to_c_rdata", c_rdata, 32'hFFFF_FFFF);
    check("to_d_rdata", d_rdata, 0);
    cyc();

    // Both requesters held from reset: CPU, DMA, CPU, DMA
    rst = 1; c_req = 1; d_req = 1; c_we = 0; d_we = 0;
    c_addr = 32'h300; d_addr = 32'h400; bus_ready = 1;
    cyc(); rst = 0;
    for (int k = 0; k < 4; k++) begin
      bus_in = 32'hA5A5_0000 + 32'(k);
      cyc(); #2;
      check("rr_owner", owner, 32'(k % 2));
      check("rr_A", bus_A, (k % 2 == 1) ? 32'h400 : 32'h300);
      cyc(); #2;
      check("rr_c_ack", c_ack, 32'(k % 2 == 0));
      check("rr_d_ack", d_ack, 32'(k % 2 == 1));
      cyc();
    end
    c_req = 0; d_req = 0; bus_ready = 0;
    check("rr_c_rdata", c_rdata, 32'hA5A5_0002);
    check("rr_d_rdata", d_rdata, 32'hA5A5_0003);

    // Reset during BUSY, then a normal CPU read
    c_req = 1; c_addr = 32'h500;
    cyc(); #2;
    check("rb_RE", bus_RE, 1);
    rst = 1; c_req = 0;
    cyc(); #2;
    check("rb_c_ack", c_ack, 0);
    check("rb_RE_off", bus_RE, 0);
    check("rb_A", bus_A, 0);
    check("rb_owner", owner, 0);
    check("rb_d_rdata", d_rdata, 0);
    rst = 0;
    c_req = 1; c_addr = 32'h600; bus_in = 32'h0BAD_F00D; bus_ready = 1;
    cyc(); c_req = 0; #2;
    check("rb2_RE", bus_RE, 1);
    check("rb2_A", bus_A, 32'h600);
    cyc(); #2;
    check("rb2_c_ack", c_ack, 1);
    check("rb2_c_rdata", c_rdata, 32'h0BAD_F00D);
    cyc(); bus_ready = 0;
    cyc();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/y86_bus_arbiter.md
Y86_BUS_ARBITER -- requirements
Module: y86_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: busy cycles without bus_ready before a transaction is aborted.
REQ-002 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports c_req/d_req  input  1  request from CPU / DMA requester.
REQ-005 SHALL have ports c_we/d_we  input  1  1 = write, 0 = read, for the CPU / DMA request.
REQ-006 SHALL have ports c_addr/d_addr  input  32  request address.
REQ-007 SHALL have ports c_wdata/d_wdata  input  32  write data.
REQ-008 SHALL have ports c_ack/d_ack  output  1  single-cycle completion pulse.
REQ-009 SHALL have ports c_rdata/d_rdata  output  32  read data, valid while the matching ack is high.
REQ-010 SHALL have port bus_A  output  32  memory address.
REQ-011 SHALL have port bus_out  output  32  memory write data.
REQ-012 SHALL have ports bus_WE/bus_RE  output  1  memory write / read strobe.
REQ-013 SHALL have port bus_in  input  32  memory read data.
REQ-014 SHALL have port bus_ready  input  1  memory completes the current access this cycle.
REQ-015 SHALL have port owner  output  1  0 = CPU, 1 = DMA; the last granted requester.
REQ-016 SHALL have port timeout_err  output  1  asserted with the ack of an aborted transaction.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-018 IDLE, no request: SHALL stay in IDLE with bus_WE = bus_RE = 0 and bus_A = 0.
REQ-019 IDLE, one request: SHALL latch that requester's we/addr/wdata, set owner, and go to BUSY next cycle.
REQ-020 IDLE, both requests: SHALL grant the requester selected by a round-robin pointer.
REQ-021 Round-robin pointer SHALL point to the requester not granted most recently, updating on each grant; CPU is preferred after reset.
REQ-022 BUSY: SHALL drive bus_A and bus_out from latched values, bus_WE = latched we, bus_RE = !latched we; requester inputs are ignored.
REQ-023 BUSY with bus_ready = 1: for a read, SHALL capture bus_in into the owner's rdata register; SHALL go to DONE.
REQ-024 A 16-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle with bus_ready = 0.
REQ-025 When the wait counter equals MAX_WAIT with bus_ready = 0: SHALL deassert strobes, load rdata with 32'hFFFFFFFF, set the timeout flag, and go to DONE.
REQ-026 DONE: SHALL pulse the owner's ack for exactly one cycle, hold timeout_err = 1 that cycle only if the transaction was aborted, keep strobes at 0, and return to IDLE.
REQ-027 Latency: request in IDLE at cycle N with bus_ready = 1 in the first BUSY cycle -> strobe at N+1, ack at N+2.
REQ-028 Latency: next grant is no earlier than the cycle after DONE, so there is at least one idle bus cycle between transactions.
REQ-029 A requester dropping req during BUSY SHALL NOT abort the transaction; the ack is still issued.
REQ-030 A requester holding req through its own ack SHALL be treated as a new request in the following IDLE, subject to round-robin.
REQ-031 The non-owner's ack and rdata SHALL be unchanged during another requester's transaction.
REQ-032 bus_ready outside BUSY SHALL be ignored.

Reset
REQ-033 On rst: state SHALL be IDLE, pointer SHALL be CPU, owner = 0, wait counter = 0.
REQ-034 On rst: all acks, strobes, timeout_err, bus_A, bus_out, c_rdata and d_rdata SHALL be 0.
REQ-035 rst SHALL take priority in any state; a transaction in flight is dropped without ack.

Verification
REQ-036 CPU read addr 0x100, bus_in = 0xDEADBEEF, bus_ready in first BUSY cycle -> bus_RE = 1 with bus_A = 0x100 for one cycle; next cycle c_ack = 1 with c_rdata = 0xDEADBEEF; d_ack = 0.
REQ-037 Both req held continuously from reset, zero wait states -> grants CPU, DMA, CPU, DMA; owner toggles; acks every 3 cycles.
REQ-038 DMA write addr 0x20, data 0x12345678, bus_ready after 3 waits -> bus_WE = 1 for 4 cycles with stable bus_A/bus_out; then one d_ack pulse; timeout_err = 0.
REQ-039 CPU read with bus_ready stuck 0 and MAX_WAIT = 15 -> strobe drops after 15 wait cycles; c_ack = 1, timeout_err = 1, c_rdata = 0xFFFFFFFF.
REQ-040 rst asserted during BUSY -> next cycle all outputs 0, no ack; the subsequent CPU request is served normally.
